// File: rtl/cpu_types_pkg.sv
// Shared status encoding between the cache/RAM arbiter and
// the RAM-side responder.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/ram_responder.sv
// Word-addressed main-memory stand-in with LAT wait states
// between request acceptance and the single ACCESS cycle.
module ram_responder
   import cpu_types_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ramREN,
   input  logic        ramWEN,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [CW-1:0] CNT_INIT =
      (LAT > 0) ? CW'(LAT - 1) : '0;
   localparam ramstate_t LAUNCH_ST = (LAT > 0) ? BUSY : ACCESS;

   ramstate_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic          op_q, op_d;

   logic [31:0]   mem [DEPTH];

   logic          req;
   logic          bad;
   logic          same;
   logic          hold;
   logic          commit;
   logic [AW-1:0] idx;

   assign req  = ramREN | ramWEN;
   assign bad  = (ramREN & ramWEN)
               | (ramaddr[1:0] != 2'b00)
               | ({2'b00, ramaddr[31:2]} >= 32'(DEPTH));
   assign same = (ramaddr == addr_q) & (ramWEN == op_q);
   assign hold = (state_q == BUSY) & same;
   assign idx  = addr_q[AW+1:2];

   // Write lands only if the requester is still presenting it.
   assign commit = (state_q == ACCESS) & op_q & ramWEN
                 & (ramaddr == addr_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      priority case (1'b1)
         !req: state_d = FREE;
         bad:  state_d = ERROR;
         hold: begin
            if (cnt_q == '0) state_d = ACCESS;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: begin
            state_d = LAUNCH_ST;
            cnt_d   = CNT_INIT;
            addr_d  = ramaddr;
            op_d    = ramWEN;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= FREE;
         cnt_q   <= '0;
         addr_q  <= '0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (commit) mem[idx] <= ramstore;
   end

   always_comb begin
      ramload = '0;
      unique case (state_q)
         ACCESS:  if (!op_q) ramload = mem[idx];
         ERROR:   ramload = 32'hBAD1_BAD1;
         default: ramload = '0;
      endcase
   end

   assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: directed scenarios plus
// random request streams against a cycle-count reference model.
module tb_ram_responder;
   import cpu_types_pkg::*;

   localparam int LAT   = 2;
   localparam int DEPTH = 1024;
   localparam int NA    = 8;

   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] ld;
      logic        chk;
   } exp_t;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ramREN = 1'b0;
   logic        ramWEN = 1'b0;
   logic [31:0] ramaddr = '0;
   logic [31:0] ramstore = '0;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   int   nvec = 0;
   int   nfail = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   // Reference model: a pending transaction completes at a known cycle.
   bit          m_pend;
   bit          m_err;
   bit          m_we;
   logic [31:0] m_addr;
   int          m_due;
   int          cyc;
   logic [31:0] mem_m [int];

   logic [31:0] addrs [NA] = '{32'h0, 32'h4, 32'h8, 32'h10,
                               32'h20, 32'h40, 32'h100, 32'hFFC};

   always #5 CLK = ~CLK;

   ram_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   function automatic void model_reset();
      m_pend = 1'b0;
      m_err  = 1'b0;
   endfunction

   function automatic void model_edge();
      bit cur_acc, cur_busy, req, bad;
      cur_acc  = m_pend && (cyc == m_due);
      cur_busy = m_pend && (cyc < m_due);
      req = ramREN || ramWEN;
      bad = (ramREN && ramWEN) || (ramaddr % 4 != 0)
         || (ramaddr / 4 >= DEPTH);
      cyc++;
      if (!nRST) begin
         model_reset();
      end else begin
         if (cur_acc && m_we && ramWEN && ramaddr == m_addr)
            mem_m[int'(m_addr / 4)] = ramstore;
         if (!req) begin
            m_pend = 1'b0;
            m_err  = 1'b0;
         end else if (bad) begin
            m_pend = 1'b0;
            m_err  = 1'b1;
         end else if (!(cur_busy && ramaddr == m_addr
                        && ramWEN == m_we)) begin
            m_pend = 1'b1;
            m_err  = 1'b0;
            m_addr = ramaddr;
            m_we   = ramWEN;
            m_due  = cyc + LAT;
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t r;
      r.st  = FREE;
      r.ld  = 32'h0;
      r.chk = 1'b1;
      if (m_err) begin
         r.st = ERROR;
         r.ld = 32'hBAD1BAD1;
      end else if (m_pend && cyc == m_due) begin
         r.st = ACCESS;
         if (!m_we) begin
            if (mem_m.exists(int'(m_addr / 4)))
               r.ld = mem_m[int'(m_addr / 4)];
            else
               r.chk = 1'b0;
         end
      end else if (m_pend) begin
         r.st = BUSY;
      end
      return r;
   endfunction

   task automatic step(input logic ren, input logic wen,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit rst);
      @(posedge CLK);
      #1;
      model_edge();
      if (rst) begin
         nRST = 1'b0;
         model_reset();
      end
      sb_q.push_back(model_out());
      ramREN   = ren;
      ramWEN   = wen;
      ramaddr  = a;
      ramstore = d;
      if (rst) begin
         #1;
         nvec++;
         if (ramstate !== FREE || ramload !== 32'h0) begin
            nfail++;
            $display("FAIL async_reset t=%0t got state=%0d load=%h exp state=0 load=0",
                     $time, ramstate, ramload);
         end
         @(negedge CLK);
         #1;
         nRST = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic hold(input logic ren, input logic wen,
                       input logic [31:0] a, input logic [31:0] d,
                       input int n);
      for (int i = 0; i < n; i++) step(ren, wen, a, d, 1'b0);
   endtask

   always @(negedge CLK) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         nvec++;
         if (ramstate !== mon_e.st
             || (mon_e.chk && ramload !== mon_e.ld)) begin
            nfail++;
            $display("FAIL resp cyc=%0d got state=%0d load=%h exp state=%0d load=%h",
                     cyc, ramstate, ramload, mon_e.st, mon_e.ld);
         end
      end
   end

   initial begin
      logic [31:0] a, d;
      logic        ren, wen;
      int          r, n;

      model_reset();
      cyc = 0;
      repeat (2) @(posedge CLK);
      #2;
      nvec++;
      if (ramstate !== FREE || ramload !== 32'h0) begin
         nfail++;
         $display("FAIL reset_state got state=%0d load=%h exp state=0 load=0",
                  ramstate, ramload);
      end
      @(negedge CLK);
      #1;
      nRST = 1'b1;

      for (int i = 0; i < NA; i++) begin
         hold(1'b0, 1'b1, addrs[i], $urandom, LAT + 2);
         idle(1);
      end

      hold(1'b1, 1'b0, 32'h40, 32'h0, LAT + 2);
      idle(2);

      hold(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, LAT + 2);
      idle(1);
      hold(1'b1, 1'b0, 32'h100, 32'h0, LAT + 2);
      idle(2);

      hold(1'b1, 1'b0, 32'h10, 32'h0, 2);
      hold(1'b1, 1'b0, 32'h20, 32'h0, LAT + 2);
      idle(2);

      hold(1'b1, 1'b1, 32'h40, 32'h11111111, 2);
      idle(1);
      hold(1'b0, 1'b1, 32'h3, 32'h22222222, 2);
      idle(1);
      hold(1'b0, 1'b1, DEPTH * 4, 32'h33333333, 2);
      idle(1);
      hold(1'b1, 1'b0, 32'h0, 32'h0, LAT + 2);
      hold(1'b1, 1'b0, 32'h40, 32'h0, LAT + 2);
      idle(1);

      hold(1'b0, 1'b1, 32'h8, 32'h12345678, 2);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      idle(1);
      hold(1'b1, 1'b0, 32'h8, 32'h0, LAT + 2);
      idle(1);

      hold(1'b1, 1'b0, 32'h4, 32'h0, 3 * (LAT + 1) + 1);
      idle(1);

      hold(1'b0, 1'b1, 32'h4, 32'hCAFEF00D, LAT + 1);
      idle(1);
      hold(1'b1, 1'b0, 32'h4, 32'h0, LAT + 2);
      idle(1);

      for (int i = 0; i < LAT + 2; i++)
         step(1'b0, 1'b1, 32'h20, 32'hA0 + 32'(i), 1'b0);
      idle(1);
      hold(1'b1, 1'b0, 32'h20, 32'h0, LAT + 2);
      idle(1);

      hold(1'b1, 1'b0, 32'hFFC, 32'h0, LAT + 2);
      idle(1);

      d = $urandom;
      repeat (80) begin
         r   = $urandom_range(0, 9);
         a   = addrs[$urandom_range(0, NA - 1)];
         ren = (r < 4) || (r == 8);
         wen = (r >= 4 && r < 8) || (r == 8);
         if (r == 9) begin
            wen = 1'(($urandom_range(0, 1)));
            ren = !wen;
            if ($urandom_range(0, 1) == 1)
               a = a | 32'($urandom_range(1, 3));
            else
               a = a + DEPTH * 4;
         end
         n = $urandom_range(1, LAT + 3);
         for (int i = 0; i < n; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 1) d = $urandom;
            step(ren, wen, a, d, ($urandom_range(0, 39) == 0));
         end
         if ($urandom_range(0, 2) == 0) idle(1);
      end

      idle(2);
      for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge CLK);
      #1;
      if (sb_q.size() != 0) begin
         nfail++;
         $display("FAIL drain got %0d pending exp 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
